turn_ctrl: RTL and testbench

- Upstream stage of the projectile block. Turns keyboard scancodes into per-player aim settings: angle 0..8 and power 0..7.
- On fire, issues a frame-aligned launch pulse with the launch coordinates.
- Tracks the shot through flight, waits for the explosion, then hands the turn to the other player.
- Runs on the system clock and samples frame_clk as a synchronised tick.

---
 rtl/turn_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_turn_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/turn_ctrl.sv
// turn_ctrl: turn controller feeding the projectile block.
// Converts HID scancodes into per-player angle (0..8) and power (0..7),
// issues a frame-aligned launch pulse with launch coordinates, follows the
// shot through flight and explosion, then hands the turn to the other player.
// All state advances on a tick derived from the rising edge of frame_clk,
// resynchronised into the clk domain.
// Optional build macro: TURN_TIMER_EN adds an aim countdown that auto-fires
// when it expires and is reported on time_left (tied to 0 otherwise).
module turn_ctrl #(
  parameter int BARREL_OFF     = 6,
  parameter int REPEAT_FRAMES  = 8,
  parameter int SETTLE_FRAMES  = 30,
  parameter int FLIGHT_TIMEOUT = 255
`ifdef TURN_TIMER_EN
  , parameter int TURN_FRAMES  = 600
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] tank0_x,
  input  logic [9:0] tank0_y,
  input  logic [9:0] tank1_x,
  input  logic [9:0] tank1_y,
  input  logic       exploded,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic       player,
  output logic       busy,
  output logic       timeout_err,
  output logic [9:0] time_left
);

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic [3:0] ANG_MAX   = 4'd8;
  localparam logic [2:0] POW_MAX   = 3'd7;

  localparam int RW = (REPEAT_FRAMES  > 1) ? $clog2(REPEAT_FRAMES)     : 1;
  localparam int SW = (SETTLE_FRAMES  > 1) ? $clog2(SETTLE_FRAMES)     : 1;
  localparam int FW = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_AIM    = 2'd0,
    S_ARM    = 2'd1,
    S_FLIGHT = 2'd2,
    S_SETTLE = 2'd3
  } state_e;

  // Synchroniser and edge-detect state
  logic [2:0]    fc_sync_q;
  logic [1:0]    ex_sync_q;
  logic          tick;
  logic          ex_s;

  // FSM and per-player settings
  state_e        state_q;
  logic          player_q;
  logic [3:0]    ang0_q, ang1_q;
  logic [2:0]    pow0_q, pow1_q;
  logic          launch_q;
  logic [9:0]    launch_x_q, launch_y_q;
  logic          busy_q;
  logic          timeout_q;
  logic          seen_low_q;
  logic [FW-1:0] flight_q;
  logic [SW-1:0] settle_q;
  logic [RW-1:0] rpt_q, rpt_d;
  logic [7:0]    key_prev_q;

  // Combinational helpers
  logic          key_new;
  logic          key_is_adj;
  logic          step;
  logic [3:0]    cur_ang, ang_d;
  logic [2:0]    cur_pow, pow_d;
  logic          space_fire;
  logic          fire;
  logic          auto_fire;
  logic [9:0]    act_x, act_y;

  // Resynchronise frame_clk (3 stages: 2 for metastability, 1 for edge) and exploded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_sync_q <= 3'b000;
      ex_sync_q <= 2'b00;
    end else begin
      fc_sync_q <= {fc_sync_q[1:0], frame_clk};
      ex_sync_q <= {ex_sync_q[0], exploded};
    end
  end

  assign tick = fc_sync_q[1] & ~fc_sync_q[2];
  assign ex_s = ex_sync_q[1];

  // Key decoding, auto-repeat and saturating adjust of the active player's settings
  always_comb begin
    key_new    = (keycode != key_prev_q);
    key_is_adj = (keycode == KEY_A) || (keycode == KEY_D) ||
                 (keycode == KEY_W) || (keycode == KEY_S);
    rpt_d      = '0;
    step       = 1'b0;
    if ((state_q == S_AIM) && key_is_adj) begin
      // First sighting steps at once; holding steps every REPEAT_FRAMES ticks
      if (key_new || (rpt_q == RW'(REPEAT_FRAMES - 1))) begin
        step  = 1'b1;
        rpt_d = '0;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end

    cur_ang = player_q ? ang1_q : ang0_q;
    cur_pow = player_q ? pow1_q : pow0_q;
    ang_d   = cur_ang;
    pow_d   = cur_pow;
    if (step) begin
      case (keycode)
        KEY_A:   if (cur_ang != 4'd0)  ang_d = cur_ang - 4'd1;
        KEY_D:   if (cur_ang != ANG_MAX) ang_d = cur_ang + 4'd1;
        KEY_W:   if (cur_pow != POW_MAX) pow_d = cur_pow + 3'd1;
        KEY_S:   if (cur_pow != 3'd0)  pow_d = cur_pow - 3'd1;
        default: ;
      endcase
    end

    // A Space held across the turn boundary is not new, so it cannot fire
    space_fire = (state_q == S_AIM) && (keycode == KEY_SPACE) && key_new;
    fire       = space_fire || auto_fire;

    act_x = player_q ? tank1_x : tank0_x;
    act_y = player_q ? tank1_y : tank0_y;
  end

`ifdef TURN_TIMER_EN
  logic [9:0] timer_q;

  // Aim countdown: reloads on every entry to AIM, decrements each AIM tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Reset is itself an entry to AIM, so the countdown starts full
      timer_q <= 10'(TURN_FRAMES);
    end else if (tick) begin
      if (state_q == S_AIM) begin
        if (timer_q != 10'd0) timer_q <= timer_q - 10'd1;
      end else if ((state_q == S_SETTLE) && (settle_q == SW'(SETTLE_FRAMES - 1))) begin
        timer_q <= 10'(TURN_FRAMES);
      end
    end
  end

  assign auto_fire = (state_q == S_AIM) && (timer_q == 10'd1);
  assign time_left = timer_q;
`else
  assign auto_fire = 1'b0;
  assign time_left = 10'd0;
`endif

  // Turn FSM with registered launch/busy/timeout outputs and stored aim settings
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_AIM;
      player_q   <= 1'b0;
      ang0_q     <= 4'd6;
      pow0_q     <= 3'd3;
      ang1_q     <= 4'd2;
      pow1_q     <= 3'd3;
      launch_q   <= 1'b0;
      launch_x_q <= 10'd0;
      launch_y_q <= 10'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      seen_low_q <= 1'b0;
      flight_q   <= '0;
      settle_q   <= '0;
      rpt_q      <= '0;
      key_prev_q <= 8'h00;
    end else if (tick) begin
      key_prev_q <= keycode;
      rpt_q      <= rpt_d;
      // Adjust is stored before a same-tick fire, so it carries into the next turn
      if (player_q) begin
        ang1_q <= ang_d;
        pow1_q <= pow_d;
      end else begin
        ang0_q <= ang_d;
        pow0_q <= pow_d;
      end

      case (state_q)
        S_AIM: begin
          if (fire) begin
            state_q    <= S_ARM;
            busy_q     <= 1'b1;
            launch_q   <= 1'b1;
            launch_x_q <= act_x;
            launch_y_q <= act_y - 10'(BARREL_OFF);
          end
        end

        S_ARM: begin
          // launch covers exactly one frame_clk rising edge
          launch_q   <= 1'b0;
          seen_low_q <= 1'b0;
          flight_q   <= '0;
          state_q    <= S_FLIGHT;
        end

        S_FLIGHT: begin
          // exploded is 1 while idle; only a 0->1 sequence marks this shot's end
          if (seen_low_q && ex_s) begin
            state_q  <= S_SETTLE;
            settle_q <= '0;
          end else begin
            if (!ex_s) seen_low_q <= 1'b1;
            flight_q <= flight_q + 1'b1;
            if (flight_q == FW'(FLIGHT_TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              state_q   <= S_SETTLE;
              settle_q  <= '0;
            end
          end
        end

        S_SETTLE: begin
          if (settle_q == SW'(SETTLE_FRAMES - 1)) begin
            settle_q <= '0;
            player_q <= ~player_q;
            busy_q   <= 1'b0;
            state_q  <= S_AIM;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        default: state_q <= S_AIM;
      endcase
    end
  end

  assign launch      = launch_q;
  assign launchX     = launch_x_q;
  assign launchY     = launch_y_q;
  assign angle       = cur_ang;
  assign power       = cur_pow;
  assign player      = player_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// tb_turn_ctrl: randomized and directed stimulus against a frame-level
// behavioural model of the turn controller.
module tb_turn_ctrl;

  localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_W = 8'h1A, K_S = 8'h16;
  localparam logic [7:0] K_SP = 8'h2C, K_OTHER = 8'h05;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] tank0_x = 10'd0, tank0_y = 10'd0, tank1_x = 10'd0, tank1_y = 10'd0;
  logic       exploded = 1'b1;
  logic       launch;
  logic [9:0] launchX, launchY;
  logic [3:0] angle;
  logic [2:0] power;
  logic       player, busy, timeout_err;
  logic [9:0] time_left;

  turn_ctrl dut (
    .clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .exploded(exploded), .launch(launch), .launchX(launchX), .launchY(launchY),
    .angle(angle), .power(power), .player(player), .busy(busy),
    .timeout_err(timeout_err), .time_left(time_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0=aiming 1=launching 2=in flight 3=settling
  int m_phase, m_player, m_launch, m_lx, m_ly, m_terr;
  int m_ang[2], m_pow[2];
  int m_prev, m_held, m_fl, m_st, m_seen;

  task automatic model_reset();
    m_phase = 0; m_player = 0; m_launch = 0; m_lx = 0; m_ly = 0; m_terr = 0;
    m_ang[0] = 6; m_pow[0] = 3; m_ang[1] = 2; m_pow[1] = 3;
    m_prev = 0; m_held = 0; m_fl = 0; m_st = 0; m_seen = 0;
  endtask

  task automatic model_frame(input int kc, input int ex);
    bit is_new, is_adj;
    int ty;
    is_new = (kc != m_prev);
    is_adj = (kc == K_A) || (kc == K_D) || (kc == K_W) || (kc == K_S);
    case (m_phase)
      0: begin
        if (is_adj) begin
          m_held = is_new ? 0 : m_held + 1;
          if (m_held % 8 == 0) begin
            if (kc == K_A) m_ang[m_player] = (m_ang[m_player] > 0) ? m_ang[m_player] - 1 : 0;
            if (kc == K_D) m_ang[m_player] = (m_ang[m_player] < 8) ? m_ang[m_player] + 1 : 8;
            if (kc == K_W) m_pow[m_player] = (m_pow[m_player] < 7) ? m_pow[m_player] + 1 : 7;
            if (kc == K_S) m_pow[m_player] = (m_pow[m_player] > 0) ? m_pow[m_player] - 1 : 0;
          end
        end else begin
          m_held = 0;
        end
        if (kc == K_SP && is_new) begin
          m_phase = 1;
          m_launch = 1;
          m_lx = m_player ? int'(tank1_x) : int'(tank0_x);
          ty   = m_player ? int'(tank1_y) : int'(tank0_y);
          m_ly = (ty + 1024 - 6) % 1024;
        end
      end
      1: begin
        m_phase = 2; m_launch = 0; m_fl = 0; m_seen = 0; m_held = 0;
      end
      2: begin
        if (m_seen != 0 && ex != 0) begin
          m_phase = 3; m_st = 0;
        end else begin
          if (ex == 0) m_seen = 1;
          m_fl++;
          if (m_fl == 255) begin
            m_terr = 1; m_phase = 3; m_st = 0;
          end
        end
      end
      default: begin
        m_st++;
        if (m_st == 30) begin
          m_player ^= 1; m_phase = 0;
        end
      end
    endcase
    m_prev = kc;
  endtask

  task automatic check_all();
    chk("angle", 32'(angle), m_ang[m_player]);
    chk("power", 32'(power), m_pow[m_player]);
    chk("player", 32'(player), m_player);
    chk("launch", 32'(launch), m_launch);
    chk("launchX", 32'(launchX), m_lx);
    chk("launchY", 32'(launchY), m_ly);
    chk("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
    chk("timeout_err", 32'(timeout_err), m_terr);
`ifndef TURN_TIMER_EN
    chk("time_left", 32'(time_left), 0);
`endif
  endtask

  // One frame: inputs settle, frame_clk pulses, outputs compared afterwards
  task automatic do_frame(input logic [7:0] kc, input logic ex);
    keycode = kc;
    exploded = ex;
    repeat (2) @(negedge clk);
    frame_clk = 1'b1;
    repeat (10) @(negedge clk);
    frame_clk = 1'b0;
    repeat (8) @(negedge clk);
    model_frame(int'(kc), int'(ex));
    check_all();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    keycode = 8'h00;
    reset = 1'b0;
    #1;
    chk("rst_player", 32'(player), 0);
    chk("rst_angle", 32'(angle), 6);
    chk("rst_power", 32'(power), 3);
    chk("rst_launch", 32'(launch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_launchY", 32'(launchY), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] key_tab [7];
  logic [7:0] kc;
  int hold;

  initial begin
    key_tab[0] = 8'h00; key_tab[1] = K_A; key_tab[2] = K_D; key_tab[3] = K_W;
    key_tab[4] = K_S;   key_tab[5] = K_SP; key_tab[6] = K_OTHER;

    repeat (3) @(negedge clk);
    apply_reset();

    // Hold D: step at first sighting, then every 8 ticks, saturating at 8
    for (int f = 0; f < 20; f++) begin
      do_frame(K_D, 1'b1);
      if (f == 0) chk("hold_d_first", 32'(angle), 7);
      if (f == 7) chk("hold_d_before_rpt", 32'(angle), 7);
      if (f == 8) chk("hold_d_rpt", 32'(angle), 8);
    end
    chk("hold_d_sat", 32'(angle), 8);
    chk("hold_d_power", 32'(power), 3);
    do_frame(8'h00, 1'b1);

    // Fire from (100,300), explosion at frame 40
    tank0_x = 10'd100; tank0_y = 10'd300; tank1_x = 10'd500; tank1_y = 10'd200;
    do_frame(K_SP, 1'b1);
    chk("fire_launch", 32'(launch), 1);
    chk("fire_x", 32'(launchX), 100);
    chk("fire_y", 32'(launchY), 294);
    chk("fire_busy", 32'(busy), 1);
    do_frame(8'h00, 1'b1);
    chk("arm_launch_low", 32'(launch), 0);
    for (int f = 2; f < 40; f++) do_frame(8'h00, 1'b0);
    do_frame(8'h00, 1'b1);
    for (int f = 0; f < 29; f++) do_frame(8'h00, 1'b1);
    chk("settle_player_hold", 32'(player), 0);
    do_frame(8'h00, 1'b1);
    chk("turn_player", 32'(player), 1);
    chk("turn_angle", 32'(angle), 2);
    chk("turn_busy", 32'(busy), 0);

    // Player 1 fires with exploded stuck high: flight timeout
    do_frame(K_SP, 1'b1);
    do_frame(8'h00, 1'b1);
    for (int f = 0; f < 254; f++) do_frame(8'h00, 1'b1);
    chk("timeout_early", 32'(timeout_err), 0);
    do_frame(8'h00, 1'b1);
    chk("timeout_set", 32'(timeout_err), 1);
    for (int f = 0; f < 30; f++) do_frame(8'h00, 1'b1);
    chk("timeout_turn", 32'(player), 0);

    // launchY wraps below zero, then reset mid-flight
    tank0_y = 10'd2;
    do_frame(K_SP, 1'b1);
    chk("wrap_y", 32'(launchY), 1020);
    do_frame(8'h00, 1'b1);
    do_frame(8'h00, 1'b0);
    do_frame(8'h00, 1'b0);
    apply_reset();

    // Randomized play
    for (int seg = 0; seg < 120; seg++) begin
      kc = key_tab[$urandom_range(0, 6)];
      hold = $urandom_range(1, 12);
      tank0_x = 10'($urandom_range(0, 1023)); tank0_y = 10'($urandom_range(0, 1023));
      tank1_x = 10'($urandom_range(0, 1023)); tank1_y = 10'($urandom_range(0, 1023));
      for (int f = 0; f < hold; f++) do_frame(kc, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
